// File: rtl/voice_mix_scheduler_pkg.sv
// Shared Q-format defaults, FSM encodings and clamp patterns for the voice mixer.
package voice_mix_scheduler_pkg;

  localparam int DEF_NUM_VOICES = 8;
  localparam int DEF_IDX_W      = 3;
  localparam int DEF_WI_S       = 2;
  localparam int DEF_WF_S       = 14;
  localparam int DEF_WI_A       = 4;
  localparam int DEF_WF_A       = 14;
  localparam int MIX_W          = DEF_WI_A + DEF_WF_A;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_OUT  = 2'd2;

  localparam logic [MIX_W-1:0] SAT_POS = {1'b0, {(MIX_W-1){1'b1}}};
  localparam logic [MIX_W-1:0] SAT_NEG = {1'b1, {(MIX_W-1){1'b0}}};

endpackage

// File: rtl/voice_mix_scheduler_adder.sv
// Signed fixed-point adder: operand 2 is aligned to operand 1's binary point,
// the sum wraps to the output width and ovf flags a lost sign bit.
module fixed_point_adder #(
  parameter int WI_1 = 4,
  parameter int WF_1 = 14,
  parameter int WI_2 = 2,
  parameter int WF_2 = 14,
  parameter int WI_O = 4,
  parameter int WF_O = 14
) (
  input  logic [WI_1+WF_1-1:0] a_i,
  input  logic [WI_2+WF_2-1:0] b_i,
  output logic [WI_O+WF_O-1:0] sum_o,
  output logic                 ovf_o
);

  localparam int W1 = WI_1 + WF_1;
  localparam int WO = WI_O + WF_O;

  logic signed [W1:0] a_ext;
  logic signed [W1:0] b_ext;
  logic signed [W1:0] full;

  // Assumes WI_1 >= WI_2, WF_1 >= WF_2 and an output format equal to operand 1.
  assign a_ext = (W1+1)'($signed(a_i));
  assign b_ext = (W1+1)'($signed(b_i)) <<< (WF_1 - WF_2);
  assign full  = a_ext + b_ext;
  assign sum_o = full[WO-1:0];
  assign ovf_o = full[W1] ^ full[W1-1];

endmodule

// File: rtl/voice_mix_scheduler.sv
// Sums NUM_VOICES operator samples through one shared adder into a saturated
// mix sample per frame and presents it over a valid/ready handshake.
module voice_mix_scheduler
  import voice_mix_scheduler_pkg::*;
#(
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int IDX_W      = DEF_IDX_W,
  parameter int WI_S       = DEF_WI_S,
  parameter int WF_S       = DEF_WF_S,
  parameter int WI_A       = DEF_WI_A,
  parameter int WF_A       = DEF_WF_A
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_tick,
  input  logic [NUM_VOICES-1:0]     voice_mute,
  output logic                      voice_req,
  output logic [IDX_W-1:0]          voice_idx,
  input  logic [WI_S+WF_S-1:0]      voice_data,
  input  logic                      voice_vld,
  output logic [WI_A+WF_A-1:0]      mix_data,
  output logic                      mix_valid,
  input  logic                      mix_ready,
  output logic                      sat_flag,
  output logic                      overrun
);

  localparam int W_A = WI_A + WF_A;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [W_A-1:0] SAT_P = (W_A == MIX_W) ? W_A'(SAT_POS) : {1'b0, {(W_A-1){1'b1}}};
  localparam logic [W_A-1:0] SAT_N = (W_A == MIX_W) ? W_A'(SAT_NEG) : {1'b1, {(W_A-1){1'b0}}};

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W_A-1:0]   acc_q, acc_d;
  logic             fsat_q, fsat_d;
  logic [W_A-1:0]   mix_q, mix_d;
  logic             sat_q, sat_d;
  logic             ovr_q, ovr_d;

  logic [W_A-1:0]   add_sum;
  logic             add_ovf;
  logic [W_A-1:0]   acc_add;
  logic             mute_cur;

  fixed_point_adder #(
    .WI_1 (WI_A),
    .WF_1 (WF_A),
    .WI_2 (WI_S),
    .WF_2 (WF_S),
    .WI_O (WI_A),
    .WF_O (WF_A)
  ) u_adder (
    .a_i   (acc_q),
    .b_i   (voice_data),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  assign mute_cur = voice_mute[idx_q];
  // On overflow both operands share the accumulator's sign, so it picks the rail.
  assign acc_add  = add_ovf ? (acc_q[W_A-1] ? SAT_N : SAT_P) : add_sum;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    fsat_d  = fsat_q;
    mix_d   = mix_q;
    sat_d   = sat_q;
    ovr_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sample_tick) begin
          state_d = ST_RUN;
          idx_d   = '0;
          acc_d   = '0;
          fsat_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (sample_tick) ovr_d = 1'b1;
        if (mute_cur || voice_vld) begin
          if (!mute_cur) begin
            acc_d  = acc_add;
            fsat_d = fsat_q | add_ovf;
          end
          if (idx_q == LAST_IDX) begin
            state_d = ST_OUT;
            mix_d   = acc_d;
            sat_d   = fsat_d;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (mix_ready) begin
          if (sample_tick) begin
            state_d = ST_RUN;
            idx_d   = '0;
            acc_d   = '0;
            fsat_d  = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (sample_tick) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      acc_q   <= '0;
      fsat_q  <= 1'b0;
      mix_q   <= '0;
      sat_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      fsat_q  <= fsat_d;
      mix_q   <= mix_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
    end
  end

  assign voice_req = (state_q == ST_RUN) && !mute_cur;
  assign voice_idx = idx_q;
  assign mix_data  = mix_q;
  assign mix_valid = (state_q == ST_OUT);
  assign sat_flag  = sat_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_voice_mix_scheduler.sv
// Directed bench for voice_mix_scheduler: a table of frames with hand-computed
// mixes plus hand-written sequences for hold, chaining, spurious valid and reset.
module tb_voice_mix_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sample_tick;
  logic [7:0]  voice_mute;
  logic        voice_req;
  logic [2:0]  voice_idx;
  logic [15:0] voice_data;
  logic        voice_vld;
  logic [17:0] mix_data;
  logic        mix_valid;
  logic        mix_ready;
  logic        sat_flag;
  logic        overrun;

  voice_mix_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .voice_mute  (voice_mute),
    .voice_req   (voice_req),
    .voice_idx   (voice_idx),
    .voice_data  (voice_data),
    .voice_vld   (voice_vld),
    .mix_data    (mix_data),
    .mix_valid   (mix_valid),
    .mix_ready   (mix_ready),
    .sat_flag    (sat_flag),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]       mute;
    logic [7:0][15:0] v;
    int               stall_idx;
    int               stall_n;
    int               tick_at;
    bit               chain;
    logic [17:0]      exp_mix;
    bit               exp_sat;
    int               exp_lat;
  } vec_t;

  logic [15:0] vals [8];
  int          stall_idx;
  int          stall_cnt;
  logic        spur;
  int          req_seen, hold_seen, ovr_seen;
  int          n_chk, n_fail;
  vec_t        vec [11];

  // Voice source: answers requests at once unless the stalled slot is still counting down.
  always_comb begin
    voice_data = vals[voice_idx];
    voice_vld  = spur | (voice_req & ~((int'(voice_idx) == stall_idx) & (stall_cnt != 0)));
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    if (voice_req) req_seen++;
    if (voice_req && int'(voice_idx) == stall_idx) hold_seen++;
    if (overrun) ovr_seen++;
    if (voice_req && int'(voice_idx) == stall_idx && stall_cnt > 0) stall_cnt--;
  endtask

  function automatic vec_t mk(logic [7:0] m, logic [7:0][15:0] v, int si, int sn, int ta,
                              bit ch, logic [17:0] em, bit es, int el);
    vec_t t;
    t.mute = m; t.v = v; t.stall_idx = si; t.stall_n = sn; t.tick_at = ta;
    t.chain = ch; t.exp_mix = em; t.exp_sat = es; t.exp_lat = el;
    return t;
  endfunction

  task automatic run_frame(input vec_t t, input int id);
    int lat;
    int exp_req;
    for (int k = 0; k < 8; k++) vals[k] = t.v[k];
    stall_idx   = t.stall_idx;
    stall_cnt   = t.stall_n;
    voice_mute  = t.mute;
    sample_tick = 1'b1;
    mix_ready   = t.chain;
    req_seen = 0; hold_seen = 0; ovr_seen = 0;
    cyc();
    sample_tick = 1'b0;
    mix_ready   = 1'b0;
    lat = 1;
    if (t.chain) chk($sformatf("v%0d_chain_valid_drop", id), mix_valid, 0);
    while (!mix_valid && lat < 200) begin
      sample_tick = (lat == t.tick_at);
      cyc();
      lat++;
    end
    sample_tick = 1'b0;
    exp_req = $countones(~t.mute) + ((t.stall_n > 0) ? t.stall_n - 1 : 0);
    chk($sformatf("v%0d_latency", id), lat, t.exp_lat);
    chk($sformatf("v%0d_mix", id), mix_data, t.exp_mix);
    chk($sformatf("v%0d_sat", id), sat_flag, t.exp_sat);
    chk($sformatf("v%0d_req_cycles", id), req_seen, exp_req);
    chk($sformatf("v%0d_overrun", id), ovr_seen, (t.tick_at != 0) ? 1 : 0);
    if (t.stall_n > 0) chk($sformatf("v%0d_hold", id), hold_seen, t.stall_n);
    stall_cnt = 0;
  endtask

  task automatic accept(input string nm);
    mix_ready = 1'b1;
    cyc();
    mix_ready = 1'b0;
    chk(nm, mix_valid, 0);
  endtask

  initial begin
    bit pending;
    int n;
    n_chk = 0; n_fail = 0;
    rst_n = 1'b0; sample_tick = 1'b0; voice_mute = '0; mix_ready = 1'b0;
    spur = 1'b0; stall_idx = 0; stall_cnt = 0;
    for (int k = 0; k < 8; k++) vals[k] = '0;

    vec[0]  = mk(8'hF0, {8{16'h4000}}, 0, 0, 0, 0, 18'h10000, 0, 9);
    vec[1]  = mk(8'h00, {8{16'h7FFF}}, 0, 0, 0, 0, 18'h1FFFF, 1, 9);
    vec[2]  = mk(8'h00, {8{16'h8000}}, 0, 0, 0, 0, 18'h20000, 1, 9);
    vec[3]  = mk(8'hFF, {8{16'h4000}}, 0, 0, 0, 0, 18'h00000, 0, 9);
    vec[4]  = mk(8'hAA, {8{16'h4000}}, 0, 0, 0, 0, 18'h10000, 0, 9);
    vec[5]  = mk(8'h00, {16'h0800, 16'h1000, 16'hFFFF, 16'h0000,
                         16'h0001, 16'h2000, 16'hC000, 16'h4000},
                 0, 0, 0, 0, 18'h03800, 0, 9);
    vec[6]  = mk(8'h00, {16'h8000, 16'h8000, 16'h8000, {5{16'h7FFF}}},
                 0, 0, 0, 0, 18'h07FFF, 1, 9);
    vec[7]  = mk(8'h00, {8{16'hF000}}, 0, 0, 0, 0, 18'h38000, 0, 9);
    vec[8]  = mk(8'h00, {8{16'h2000}}, 2, 4, 0, 0, 18'h10000, 0, 12);
    vec[9]  = mk(8'h0F, {8{16'h2000}}, 0, 0, 3, 0, 18'h08000, 0, 9);
    vec[10] = mk(8'h00, {8{16'h0800}}, 0, 0, 0, 1, 18'h04000, 0, 9);

    cyc(); cyc();
    chk("rst_req", voice_req, 0);
    chk("rst_idx", voice_idx, 0);
    chk("rst_mix", mix_data, 0);
    chk("rst_valid", mix_valid, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_overrun", overrun, 0);
    rst_n = 1'b1;
    cyc();

    pending = 0;
    for (int i = 0; i < 11; i++) begin
      if (pending && !vec[i].chain) accept($sformatf("v%0d_accept", i));
      run_frame(vec[i], i);
      pending = 1;
    end

    // Held output: tick while waiting for mix_ready is dropped with one overrun pulse.
    ovr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      sample_tick = (i == 1);
      cyc();
      chk($sformatf("hold%0d_mix", i), mix_data, 18'h04000);
      chk($sformatf("hold%0d_valid", i), mix_valid, 1);
    end
    sample_tick = 1'b0;
    chk("hold_overrun", ovr_seen, 1);
    accept("hold_accept");

    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("spur%0d_req", i), voice_req, 0);
      chk($sformatf("spur%0d_valid", i), mix_valid, 0);
    end
    spur = 1'b0;
    chk("spur_mix", mix_data, 18'h04000);
    run_frame(vec[7], 20);
    accept("spur_accept");

    // Reset in the middle of voice 5 must clear everything immediately.
    for (int k = 0; k < 8; k++) vals[k] = 16'h2000;
    voice_mute  = 8'h00;
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    n = 0;
    while (!(voice_idx == 3'd5 && voice_req) && n < 20) begin
      cyc();
      n++;
    end
    chk("rst_mid_reached_v5", (n < 20) ? 1 : 0, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", voice_req, 0);
    chk("rst_mid_idx", voice_idx, 0);
    chk("rst_mid_mix", mix_data, 0);
    chk("rst_mid_valid", mix_valid, 0);
    chk("rst_mid_sat", sat_flag, 0);
    chk("rst_mid_overrun", overrun, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();
    run_frame(vec[0], 30);
    accept("post_rst_accept");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
